// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion paths on the lab board.
// Holds the converter state encoding and the double-dabble digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DD_THRESH = 4'd8;
  localparam logic [3:0] DD_CORR   = 4'd3;

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble correction for one BCD digit after a right shift.
// A digit at 8 or above only got there from a carried-in tens bit, so take 3 off.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= DD_THRESH) ? (i_digit - DD_CORR) : i_digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// start/busy/done handshake; any nibble above 9 is rejected with err and a zero result.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_bcd_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BIN_W-1:0]      o_bin_out,
  output logic                  o_err
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t              r_state;
  logic [4*DIGITS-1:0] r_bcdReg;
  logic [BIN_W-1:0]    r_binReg;
  logic [CNT_W-1:0]    r_count;
  logic                r_errNext;

  logic [4*DIGITS-1:0] w_bcdShift;
  logic [4*DIGITS-1:0] w_bcdCorr;
  logic                w_invalid;

  assign w_bcdShift = r_bcdReg >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit(w_bcdShift[4*g +: 4]),
      .o_digit(w_bcdCorr[4*g +: 4])
    );
  end

  always_comb begin
    w_invalid = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_bcd_in[4*d +: 4] > DIGIT_MAX) w_invalid = 1'b1;
    end
  end

  // Bad input skips the shift phase entirely and reports straight from DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_bcdReg  <= '0;
      r_binReg  <= '0;
      r_count   <= '0;
      r_errNext <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_bin_out <= '0;
      o_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_bcdReg <= i_bcd_in;
            r_binReg <= '0;
            r_count  <= '0;
            if (w_invalid) begin
              r_errNext <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_errNext <= 1'b0;
              o_busy    <= 1'b1;
              r_state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_bcdReg <= w_bcdCorr;
          r_binReg <= {r_bcdReg[0], r_binReg[BIN_W-1:1]};
          r_count  <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(BIN_W - 1)) begin
            o_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          o_bin_out <= r_errNext ? '0 : r_binReg;
          o_err     <= r_errNext;
          o_done    <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Every BCD bit must have migrated into the binary register by the end of a valid run.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && r_state == DONE && !r_errNext) assert (r_bcdReg == '0);
  end

endmodule
